// File: rtl/wb_back_broadcast_if.sv
// Bus between the execution units, the writeback broadcast queue and the
// RAW hazard checker that consumes the broadcast slots.
//
// Signals:
//   fu_k_vld / fu_k_des (k=1..4)     completion report from execution unit k
//   fu_k_rdy (k=1..4)                queue accepts unit k's report this cycle
//   ins_back_n_vld / _des (n=1..4)   released destination tags, n=1 is oldest
//   q_count                          entries still held in the queue
//
// Modports:
//   slave  - the broadcast queue itself
//   master - the environment (execution units plus hazard checker)
interface wb_back_broadcast_if #(
  parameter int des   = 4,
  parameter int cnt_w = 4
);
  logic           fu_1_vld, fu_2_vld, fu_3_vld, fu_4_vld;
  logic [des-1:0] fu_1_des, fu_2_des, fu_3_des, fu_4_des;
  logic           fu_1_rdy, fu_2_rdy, fu_3_rdy, fu_4_rdy;

  logic           ins_back_1_vld, ins_back_2_vld, ins_back_3_vld, ins_back_4_vld;
  logic [des-1:0] ins_back_1_des, ins_back_2_des, ins_back_3_des, ins_back_4_des;

  logic [cnt_w-1:0] q_count;

  modport slave (
    input  fu_1_vld, fu_2_vld, fu_3_vld, fu_4_vld,
    input  fu_1_des, fu_2_des, fu_3_des, fu_4_des,
    output fu_1_rdy, fu_2_rdy, fu_3_rdy, fu_4_rdy,
    output ins_back_1_vld, ins_back_2_vld, ins_back_3_vld, ins_back_4_vld,
    output ins_back_1_des, ins_back_2_des, ins_back_3_des, ins_back_4_des,
    output q_count
  );

  modport master (
    output fu_1_vld, fu_2_vld, fu_3_vld, fu_4_vld,
    output fu_1_des, fu_2_des, fu_3_des, fu_4_des,
    input  fu_1_rdy, fu_2_rdy, fu_3_rdy, fu_4_rdy,
    input  ins_back_1_vld, ins_back_2_vld, ins_back_3_vld, ins_back_4_vld,
    input  ins_back_1_des, ins_back_2_des, ins_back_3_des, ins_back_4_des,
    input  q_count
  );
endinterface

// File: rtl/wb_back_broadcast.sv
// Writeback broadcast queue. Collects destination-tag completion reports from
// four execution-unit ports into an ordered circular FIFO and replays them,
// oldest first, up to four per cycle on the ins_back broadcast bus feeding
// the RAW hazard check. Execution units are back-pressured through fu_k_rdy
// whenever the FIFO cannot take k more entries.
//
// Ports:
//   clk    single clock, all state changes on the rising edge
//   rst    synchronous reset, active-low
//   flush  synchronous flush, discards every queued completion
//   bus    wb_back_broadcast_if.slave: fu_k_vld/des/rdy inputs from the
//          execution units, ins_back_n_vld/des broadcast outputs, q_count
module wb_back_broadcast #(
  parameter int des   = 4,
  parameter int depth = 8,
  parameter int cnt_w = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  wb_back_broadcast_if.slave    bus
);

  localparam int ptr_w = $clog2(depth);

  logic [des-1:0]       mem [depth];
  logic [ptr_w-1:0]     rd_ptr, wr_ptr;
  logic [cnt_w-1:0]     count, free;
  logic [3:0]           req, rdy, acc;
  logic [3:0][des-1:0]  req_des;
  logic [ptr_w-1:0]     wr_idx [4];
  logic [2:0]           push, pop;
  logic [3:0]           bc_vld;
  logic [3:0][des-1:0]  bc_des;

  always_comb begin
    req        = {bus.fu_4_vld, bus.fu_3_vld, bus.fu_2_vld, bus.fu_1_vld};
    req_des[0] = bus.fu_1_des;
    req_des[1] = bus.fu_2_des;
    req_des[2] = bus.fu_3_des;
    req_des[3] = bus.fu_4_des;
  end

  // Ready depends only on registered occupancy so it never loops back through
  // the execution units' valid logic; this cycle's drain is not credited.
  always_comb begin
    free = cnt_w'(depth) - count;
    for (int k = 0; k < 4; k++) begin
      rdy[k] = (free >= cnt_w'(k + 1)) && !flush && rst;
    end
    acc = req & rdy;
  end

  // Accepted ports are packed into consecutive slots in port order, so gaps
  // between accepted ports do not leave holes in the FIFO.
  always_comb begin
    push = 3'd0;
    for (int k = 0; k < 4; k++) begin
      wr_idx[k] = wr_ptr + ptr_w'(push);
      push      = push + {2'b00, acc[k]};
    end
  end

  assign pop = (count >= cnt_w'(4)) ? 3'd4 : 3'(count);

  // Storage is never cleared; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (acc[k]) begin
        mem[wr_idx[k]] <= req_des[k];
      end
    end
  end

  // Slots being written this edge are always outside the counted region, so
  // the drain reads only entries pushed on earlier edges.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      bc_vld <= '0;
      bc_des <= '0;
    end else begin
      rd_ptr <= rd_ptr + ptr_w'(pop);
      wr_ptr <= wr_ptr + ptr_w'(push);
      count  <= count - cnt_w'(pop) + cnt_w'(push);
      for (int n = 0; n < 4; n++) begin
        if (3'(n) < pop) begin
          bc_vld[n] <= 1'b1;
          bc_des[n] <= mem[rd_ptr + ptr_w'(n)];
        end else begin
          bc_vld[n] <= 1'b0;
          bc_des[n] <= '0;
        end
      end
    end
  end

  assign bus.fu_1_rdy = rdy[0];
  assign bus.fu_2_rdy = rdy[1];
  assign bus.fu_3_rdy = rdy[2];
  assign bus.fu_4_rdy = rdy[3];

  assign bus.ins_back_1_vld = bc_vld[0];
  assign bus.ins_back_2_vld = bc_vld[1];
  assign bus.ins_back_3_vld = bc_vld[2];
  assign bus.ins_back_4_vld = bc_vld[3];
  assign bus.ins_back_1_des = bc_des[0];
  assign bus.ins_back_2_des = bc_des[1];
  assign bus.ins_back_3_des = bc_des[2];
  assign bus.ins_back_4_des = bc_des[3];

  assign bus.q_count = count;

endmodule

// File: tb/tb_wb_back_broadcast.sv
// Testbench for wb_back_broadcast. The reference model is a plain queue of
// tags: each edge pops up to four from the front into the expected broadcast
// and appends the accepted requests in port order.
module tb_wb_back_broadcast;

  localparam int DES   = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [3:0]     fuVld;
  logic [DES-1:0] fuDes [4];

  int numCompared   = 0;
  int numMismatched = 0;
  int modelQ[$];
  int nextTag = 0;
  logic [3:0] lastAcc;

  wb_back_broadcast_if #(.des(DES), .cnt_w(CNT_W)) bus ();

  assign bus.fu_1_vld = fuVld[0];
  assign bus.fu_2_vld = fuVld[1];
  assign bus.fu_3_vld = fuVld[2];
  assign bus.fu_4_vld = fuVld[3];
  assign bus.fu_1_des = fuDes[0];
  assign bus.fu_2_des = fuDes[1];
  assign bus.fu_3_des = fuDes[2];
  assign bus.fu_4_des = fuDes[3];

  wb_back_broadcast #(.des(DES), .depth(DEPTH), .cnt_w(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Applies the currently driven inputs for one clock edge, advances the
  // queue model and checks ready before the edge and outputs after it.
  task automatic applyStimulus(output logic [3:0] accepted);
    logic [3:0] expRdy;
    logic [3:0] obsVld;
    logic [DES-1:0] obsDes [4];
    int freeSlots;
    int popped[$];
    int nPop;
    #1;
    freeSlots = DEPTH - modelQ.size();
    for (int k = 0; k < 4; k++)
      expRdy[k] = rst && !flush && (freeSlots >= k + 1);
    checkOutput("rdy", {28'd0, bus.fu_4_rdy, bus.fu_3_rdy, bus.fu_2_rdy, bus.fu_1_rdy},
                {28'd0, expRdy});
    accepted = fuVld & expRdy;
    if (!rst || flush) begin
      modelQ.delete();
      accepted = 4'd0;
    end else begin
      nPop = (modelQ.size() < 4) ? modelQ.size() : 4;
      for (int i = 0; i < nPop; i++) popped.push_back(modelQ.pop_front());
      for (int k = 0; k < 4; k++)
        if (accepted[k]) modelQ.push_back(int'(fuDes[k]));
    end
    @(posedge clk);
    #1;
    obsVld = {bus.ins_back_4_vld, bus.ins_back_3_vld, bus.ins_back_2_vld, bus.ins_back_1_vld};
    obsDes[0] = bus.ins_back_1_des;
    obsDes[1] = bus.ins_back_2_des;
    obsDes[2] = bus.ins_back_3_des;
    obsDes[3] = bus.ins_back_4_des;
    for (int n = 0; n < 4; n++) begin
      checkOutput($sformatf("slot%0d_vld", n + 1), {31'd0, obsVld[n]},
                  (n < popped.size()) ? 32'd1 : 32'd0);
      checkOutput($sformatf("slot%0d_des", n + 1), {28'd0, obsDes[n]},
                  (n < popped.size()) ? 32'(popped[n]) : 32'd0);
    end
    checkOutput("q_count", {28'd0, bus.q_count}, 32'(modelQ.size()));
  endtask

  task automatic setPorts(input logic [3:0] v, input int d1, input int d2,
                          input int d3, input int d4);
    fuVld    = v;
    fuDes[0] = DES'(d1);
    fuDes[1] = DES'(d2);
    fuDes[2] = DES'(d3);
    fuDes[3] = DES'(d4);
  endtask

  // Random producer: accepted ports take a fresh sequential tag or go idle,
  // ports that were not accepted keep their request unchanged.
  task automatic refillPorts(input int pct);
    for (int k = 0; k < 4; k++) begin
      if (!fuVld[k] || lastAcc[k]) begin
        if ($urandom_range(99) < pct) begin
          fuVld[k] = 1'b1;
          fuDes[k] = DES'(nextTag);
          nextTag  = (nextTag + 1) % 16;
        end else begin
          fuVld[k] = 1'b0;
          fuDes[k] = '0;
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    setPorts(4'b0001, 7, 0, 0, 0);
    lastAcc = 4'd0;

    // Reset held with a pending request
    repeat (2) applyStimulus(lastAcc);
    rst = 1'b1;
    setPorts(4'b0000, 0, 0, 0, 0);
    applyStimulus(lastAcc);

    // Single completion latency
    setPorts(4'b0010, 0, 5, 0, 0);
    applyStimulus(lastAcc);
    setPorts(4'b0000, 0, 0, 0, 0);
    repeat (2) applyStimulus(lastAcc);

    // Compaction and ordering
    setPorts(4'b1101, 3, 0, 9, 12);
    applyStimulus(lastAcc);
    setPorts(4'b1111, 1, 2, 4, 6);
    applyStimulus(lastAcc);
    setPorts(4'b0000, 0, 0, 0, 0);
    repeat (3) applyStimulus(lastAcc);

    // Sustained full-rate traffic
    for (int c = 0; c < 6; c++) begin
      setPorts(4'b1111, 4 * c, 4 * c + 1, 4 * c + 2, 4 * c + 3);
      applyStimulus(lastAcc);
    end
    setPorts(4'b0000, 0, 0, 0, 0);
    repeat (2) applyStimulus(lastAcc);

    // Random traffic across many pointer wraps
    lastAcc = 4'd0;
    for (int c = 0; c < 60; c++) begin
      refillPorts(int'($urandom_range(20, 95)));
      applyStimulus(lastAcc);
    end

    // Random traffic with occasional flushes
    for (int c = 0; c < 40; c++) begin
      flush = ($urandom_range(9) == 0);
      refillPorts(70);
      applyStimulus(lastAcc);
    end
    flush = 1'b0;
    setPorts(4'b0000, 0, 0, 0, 0);
    repeat (2) applyStimulus(lastAcc);

    // Flush mid-operation with a request present
    for (int c = 0; c < 3; c++) begin
      setPorts(4'b1111, c + 8, c + 9, c + 10, c + 11);
      applyStimulus(lastAcc);
    end
    flush = 1'b1;
    setPorts(4'b0001, 13, 0, 0, 0);
    applyStimulus(lastAcc);
    flush = 1'b0;
    setPorts(4'b0000, 0, 0, 0, 0);
    repeat (2) applyStimulus(lastAcc);

    // Reset and flush together mid-operation
    for (int c = 0; c < 3; c++) begin
      setPorts(4'b0111, c + 1, c + 2, c + 3, 0);
      applyStimulus(lastAcc);
    end
    rst   = 1'b0;
    flush = 1'b1;
    setPorts(4'b0001, 14, 0, 0, 0);
    applyStimulus(lastAcc);
    rst   = 1'b1;
    flush = 1'b0;
    setPorts(4'b0000, 0, 0, 0, 0);
    repeat (2) applyStimulus(lastAcc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
